// File: rtl/led_key_ctrl_pkg.sv
// led_pkg: mode encoding and counter width helper shared by led_key_ctrl and key_debounce
package led_pkg;
  typedef enum logic [1:0] {OFF = 2'b00, ON = 2'b01, BLINK = 2'b10} mode_t;
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/led_key_ctrl_if.sv
// led_key_ctrl_if: key_in/en in, led_out/press_pulse out; master drives keys, slave is the controller
interface led_key_ctrl_if #(parameter int NUM_CH = 4);
  logic [NUM_CH-1:0] key_in;
  logic [NUM_CH-1:0] led_out;
  logic [NUM_CH-1:0] press_pulse;
  logic en;
  modport master (output key_in, en, input led_out, press_pulse);
  modport slave (input key_in, en, output led_out, press_pulse);
endinterface

// File: rtl/led_key_ctrl_debounce.sv
// key_debounce: clk/rst, raw key in -> 2-flop sync, debounce to accepted level, registered press strobe on 0->1
module key_debounce
  import led_pkg::*;
#(
  parameter int DEB_CYCLES = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic key,
  output logic press
);
  localparam int W = cnt_w(DEB_CYCLES);
  logic s1, s2, acc, diff, done;
  logic [W-1:0] cnt;
  assign diff = s2 ^ acc;
  assign done = diff && (cnt == W'(DEB_CYCLES - 1));
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      acc <= 1'b0;
      cnt <= '0;
      press <= 1'b0;
    end else begin
      s1 <= key;
      s2 <= s1;
      acc <= done ? s2 : acc;
      cnt <= (diff && !done) ? cnt + 1'b1 : '0;
      press <= done && s2;
    end
  end
endmodule

// File: rtl/led_key_ctrl.sv
// led_key_ctrl: clk/rst plus io (key_in, en -> led_out, press_pulse); per-channel OFF/ON/BLINK mode stepped by debounced presses
module led_key_ctrl
  import led_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DEB_CYCLES = 20,
  parameter int BLINK_HALF = 50
) (
  input logic clk,
  input logic rst,
  led_key_ctrl_if.slave io
);
  localparam int BW = cnt_w(BLINK_HALF);
  logic [NUM_CH-1:0] press;
  logic [BW-1:0] bcnt;
  logic phase, wrap;
  mode_t mode_q [NUM_CH];
  mode_t mode_d [NUM_CH];
  assign wrap = (bcnt == BW'(BLINK_HALF - 1));
  assign io.press_pulse = press;
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk(clk),
      .rst(rst),
      .key(io.key_in[i]),
      .press(press[i])
    );
    assign io.led_out[i] = io.en && (mode_q[i] == ON || (mode_q[i] == BLINK && phase));
  end
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      mode_d[i] = mode_q[i];
      if (press[i]) mode_d[i] = (mode_q[i] == OFF) ? ON : (mode_q[i] == ON) ? BLINK : OFF;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      bcnt <= '0;
      phase <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) mode_q[i] <= OFF;
    end else begin
      bcnt <= wrap ? '0 : bcnt + 1'b1;
      phase <= phase ^ wrap;
      for (int i = 0; i < NUM_CH; i++) mode_q[i] <= mode_d[i];
    end
  end
endmodule

// File: tb/tb_led_key_ctrl.sv
// tb_led_key_ctrl: directed self-checking bench for led_key_ctrl with NUM_CH=3, DEB_CYCLES=4, BLINK_HALF=3
module tb_led_key_ctrl;
  localparam int N = 3;
  localparam int D = 4;
  localparam int B = 3;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int chk = 0;
  int fails = 0;
  int cyc = 0;
  int em [N];
  always #5 clk = ~clk;
  led_key_ctrl_if #(.NUM_CH(N)) io ();
  led_key_ctrl #(.NUM_CH(N), .DEB_CYCLES(D), .BLINK_HALF(B)) dut (
    .clk(clk),
    .rst(rst),
    .io(io)
  );
  always @(posedge clk) cyc <= rst ? 0 : cyc + 1;
  function automatic logic [N-1:0] led_exp();
    logic [N-1:0] r;
    logic ph;
    ph = ((cyc / B) % 2) == 1;
    for (int i = 0; i < N; i++) r[i] = io.en && (em[i] == 1 || (em[i] == 2 && ph));
    return r;
  endfunction
  task automatic tick(input logic [N-1:0] ep, input string tag);
    logic [N-1:0] le;
    @(posedge clk);
    @(negedge clk);
    le = led_exp();
    chk++;
    assert (io.led_out === le) else begin
      fails++;
      $error("FAIL %s led_out got %b exp %b", tag, io.led_out, le);
    end
    chk++;
    assert (io.press_pulse === ep) else begin
      fails++;
      $error("FAIL %s press_pulse got %b exp %b", tag, io.press_pulse, ep);
    end
  endtask
  task automatic wait_press(input logic [N-1:0] mask, input string tag);
    for (int t = 1; t <= 7; t++) begin
      tick((t == D + 2) ? mask : '0, tag);
      if (t == D + 2)
        for (int i = 0; i < N; i++) if (mask[i]) em[i] = (em[i] + 1) % 3;
    end
  endtask
  task automatic press(input logic [N-1:0] mask, input string tag);
    io.key_in = io.key_in | mask;
    wait_press(mask, tag);
    io.key_in = io.key_in & ~mask;
    repeat (8) tick('0, {tag, "_rel"});
  endtask
  task automatic do_reset(input logic [N-1:0] key);
    rst = 1'b1;
    io.key_in = key;
    for (int i = 0; i < N; i++) em[i] = 0;
    tick('0, "rst");
    rst = 1'b0;
  endtask
  initial begin
    for (int i = 0; i < N; i++) em[i] = 0;
    io.en = 1'b1;
    io.key_in = 3'b111;
    repeat (3) tick('0, "rst_hold");
    rst = 1'b0;
    wait_press(3'b111, "held_rst");
    io.key_in = '0;
    repeat (8) tick('0, "rel_all");
    do_reset('0);
    press(3'b001, "ch0_on");
    for (int t = 0; t < 12; t++) begin
      io.key_in[1] = (t % 4) < 2;
      tick('0, "bounce");
    end
    io.key_in[1] = 1'b1;
    wait_press(3'b010, "ch1_final");
    io.key_in = '0;
    repeat (8) tick('0, "ch1_rel");
    press(3'b100, "ch2_on");
    press(3'b100, "ch2_blink");
    repeat (12) tick('0, "ch2_blinking");
    press(3'b100, "ch2_off");
    io.en = 1'b0;
    repeat (4) tick('0, "en0");
    press(3'b001, "en0_press");
    repeat (6) tick('0, "en0_blink");
    io.en = 1'b1;
    repeat (8) tick('0, "en1_blink");
    io.key_in = 3'b010;
    repeat (3) tick('0, "mid_deb");
    do_reset('0);
    repeat (10) tick('0, "post_rst");
    press(3'b001, "pr_on");
    press(3'b001, "pr_blink");
    repeat (8) tick('0, "pr_blinking");
    $display("%0d/%0d checks passed", chk - fails, chk);
    $finish;
  end
endmodule
